// File: rtl/rv_run_ctrl.sv
// rv_run_ctrl: run controller and completion monitor for the rv_pl pipeline.
// It sequences the core reset, counts RUN cycles, detects halt instructions
// on the retire stream and captures one watched register from writeback.
// Optional build macro RV_RUN_CTRL_PERF_EN adds retire_cnt and perf_sat.
module rv_run_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     CNT_W      = 32,
  parameter int unsigned     RST_CYCLES = 2,
  parameter int unsigned     TIMEOUT    = 200,
  parameter int unsigned     WATCH_REG  = 10,
  parameter logic [XLEN-1:0] EXPECT     = XLEN'(55)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [31:0]      retire_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  result,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef RV_RUN_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             perf_sat
`endif
);

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_JSELF  = 32'h0000_006F;
  localparam int unsigned RC_W         = $clog2(RST_CYCLES + 1);
  localparam logic [4:0]  WATCH_IDX    = 5'(WATCH_REG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              busy_d;
  logic              core_rst_n_d;
  logic [RC_W-1:0]   rst_cnt;
  logic              halt;
  logic              at_limit;
  logic              capture;
  logic [XLEN-1:0]   result_new;
  logic [CNT_W-1:0]  cycle_inc;

  // The retire PC is not needed to recognise a halt; it is only folded here.
  logic unused_pc;
  assign unused_pc = ^retire_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign halt       = retire_valid && ((retire_instr == INSTR_EBREAK) ||
                                       (retire_instr == INSTR_ECALL)  ||
                                       (retire_instr == INSTR_JSELF));
  assign at_limit   = (cycle_cnt == CNT_W'(TIMEOUT - 1));
  assign capture    = (state_q == ST_RUN) && wb_en && (WATCH_REG != 0) &&
                      (wb_rd == WATCH_IDX);
  // A write landing in the halt cycle must be the value pass is judged on.
  assign result_new = capture ? wb_data : result;
  assign cycle_inc  = sat_inc(cycle_cnt);

  // State register plus the registered state-decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= busy_d;
      core_rst_n <= core_rst_n_d;
    end
  end

  // Next-state logic; halt takes priority over the timeout limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RESET;
      ST_RESET:         if (rst_cnt == RC_W'(1)) state_d = ST_RUN;
      ST_RUN:           if (halt || at_limit) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so busy/core_rst_n come from flops.
  always_comb begin
    busy_d       = 1'b0;
    core_rst_n_d = 1'b0;
    case (state_d)
      ST_RESET: busy_d = 1'b1;
      ST_RUN: begin
        busy_d       = 1'b1;
        core_rst_n_d = 1'b1;
      end
      ST_DONE:  core_rst_n_d = 1'b1;
      default: ;
    endcase
  end

  // Run bookkeeping: reset countdown, cycle count, capture and verdict flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      result    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rst_cnt   <= RC_W'(RST_CYCLES);
            cycle_cnt <= '0;
            result    <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_RESET: rst_cnt <= rst_cnt - RC_W'(1);
        ST_RUN: begin
          cycle_cnt <= cycle_inc;
          if (capture) result <= wb_data;
          if (halt) begin
            done <= 1'b1;
            pass <= (result_new == EXPECT);
          end else if (at_limit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RV_RUN_CTRL_PERF_EN
  logic [CNT_W-1:0] retire_inc;
  assign retire_inc = sat_inc(retire_cnt);

  // Retire counter and sticky saturation flag, both cleared by a new run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      perf_sat   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            retire_cnt <= '0;
            perf_sat   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (retire_valid) retire_cnt <= retire_inc;
          if ((&cycle_inc) || (retire_valid && (&retire_inc))) perf_sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Testbench for rv_run_ctrl: directed vector table, hand sequences for the
// start-up, Fibonacci, timeout and async-reset cases, then random runs
// checked against a timestamp-based reference model.
module tb_rv_run_ctrl;

  localparam int          RST = 2;
  localparam int          TMO = 200;
  localparam logic [31:0] EXP = 32'd55;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] JAL0   = 32'h0000_006F;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] result;
  logic [31:0] cycle_cnt;
`ifdef RV_RUN_CTRL_PERF_EN
  logic [31:0] retire_cnt;
  logic        perf_sat;
`endif

  always #5 clk = ~clk;

  rv_run_ctrl #(
    .XLEN(32), .CNT_W(32), .RST_CYCLES(RST), .TIMEOUT(TMO),
    .WATCH_REG(10), .EXPECT(EXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .result(result), .cycle_cnt(cycle_cnt)
`ifdef RV_RUN_CTRL_PERF_EN
    , .retire_cnt(retire_cnt), .perf_sat(perf_sat)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: a run is described by the cycle its start was accepted
  // and the cycle it ended; everything else is derived from those stamps.
  int          mc;
  bit          m_started;
  bit          m_ended;
  int          m_start;
  int          m_end;
  logic [31:0] m_res;
  bit          m_pass;
  bit          m_to;
  int          m_ret;

  function automatic bit is_halt(input logic [31:0] ins);
    return (ins == EBREAK) || (ins == ECALL) || (ins == JAL0);
  endfunction

  function automatic bit m_can_start();
    return !m_started || m_ended;
  endfunction

  task automatic model_clear();
    m_started = 0; m_ended = 0; m_start = 0; m_end = 0;
    m_res = '0; m_pass = 0; m_to = 0; m_ret = 0;
  endtask

  task automatic model_edge(input logic st, input logic rv, input logic [31:0] ins,
                            input logic we, input logic [4:0] rd, input logic [31:0] wd);
    int r;
    r = m_start + RST + 1;
    if (m_can_start()) begin
      if (st) begin
        m_started = 1; m_ended = 0; m_start = mc;
        m_res = '0; m_pass = 0; m_to = 0; m_ret = 0;
      end
    end else if (mc >= r) begin
      if (we && rd == 5'd10) m_res = wd;
      if (rv) m_ret++;
      if (rv && is_halt(ins)) begin
        m_ended = 1; m_end = mc; m_pass = (m_res == EXP);
      end else if (mc - r == TMO - 1) begin
        m_ended = 1; m_end = mc; m_to = 1;
      end
    end
    mc++;
  endtask

  task automatic check_model();
    logic e_core;
    logic e_busy;
    int   e_cnt;
    int   r;
    r = m_start + RST + 1;
    if (!m_started) begin
      e_core = 0; e_busy = 0; e_cnt = 0;
    end else if (m_ended) begin
      e_core = 1; e_busy = 0; e_cnt = m_end - r + 1;
    end else if (mc <= m_start + RST) begin
      e_core = 0; e_busy = 1; e_cnt = 0;
    end else begin
      e_core = 1; e_busy = 1; e_cnt = mc - r;
    end
    chk("model core_rst_n", core_rst_n, e_core);
    chk("model busy", busy, e_busy);
    chk("model done", done, m_started && m_ended);
    chk("model pass", pass, m_pass);
    chk("model timeout", timeout, m_to);
    chk("model result", result, m_res);
    chk("model cycle_cnt", cycle_cnt, e_cnt);
`ifdef RV_RUN_CTRL_PERF_EN
    chk("model retire_cnt", retire_cnt, m_ret);
    chk("model perf_sat", perf_sat, 0);
`endif
  endtask

  // One clock: drive inputs, advance model and DUT, compare after the edge.
  task automatic tick(input logic st, input logic rv, input logic [31:0] ins,
                      input logic we, input logic [4:0] rd, input logic [31:0] wd);
    start = st; retire_valid = rv; retire_instr = ins;
    wb_en = we; wb_rd = rd; wb_data = wd; retire_pc = $urandom;
    model_edge(st, rv, ins, we, rd, wd);
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] v;
    v = $urandom;
    v[6:0] = 7'h13;
    return v;
  endfunction

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        e_core;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic        e_to;
    logic [31:0] e_res;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] ins,
                              input logic we, input logic [4:0] rd, input logic [31:0] wd,
                              input logic ec, input logic eb, input logic ed,
                              input logic ep, input logic et, input logic [31:0] er);
    vec_t v;
    v.st = st; v.rv = rv; v.ins = ins; v.we = we; v.rd = rd; v.wd = wd;
    v.e_core = ec; v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_to = et; v.e_res = er;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] ft;
    int          n;

    //            st rv ins     we rd  wd    core busy done pass to res
    vecs[0]  = mk(1, 0, NOP,    0, 0,  0,    0,   1,   0,   0,   0, 0);
    vecs[1]  = mk(0, 0, NOP,    0, 0,  0,    0,   1,   0,   0,   0, 0);
    vecs[2]  = mk(0, 1, ECALL,  1, 10, 77,   1,   1,   0,   0,   0, 0);
    vecs[3]  = mk(0, 1, NOP,    1, 10, 54,   1,   1,   0,   0,   0, 54);
    vecs[4]  = mk(0, 0, NOP,    1, 0,  55,   1,   1,   0,   0,   0, 54);
    vecs[5]  = mk(1, 1, NOP,    1, 11, 55,   1,   1,   0,   0,   0, 54);
    vecs[6]  = mk(0, 1, ECALL,  0, 0,  0,    1,   0,   1,   0,   0, 54);
    vecs[7]  = mk(0, 0, NOP,    0, 0,  0,    1,   0,   1,   0,   0, 54);
    vecs[8]  = mk(0, 1, EBREAK, 1, 10, 55,   1,   0,   1,   0,   0, 54);
    vecs[9]  = mk(1, 1, ECALL,  0, 0,  0,    0,   1,   0,   0,   0, 0);
    vecs[10] = mk(0, 0, NOP,    0, 0,  0,    0,   1,   0,   0,   0, 0);
    vecs[11] = mk(1, 0, NOP,    0, 0,  0,    1,   1,   0,   0,   0, 0);
    vecs[12] = mk(0, 1, JAL0,   1, 10, 55,   1,   0,   1,   1,   0, 55);
    vecs[13] = mk(0, 1, EBREAK, 0, 0,  0,    1,   0,   1,   1,   0, 55);

    start = 0; retire_valid = 0; retire_pc = 0; retire_instr = NOP;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    mc = 0;
    model_clear();

    // Power-on reset, held for two clocks.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset core_rst_n", core_rst_n, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset cycle_cnt", cycle_cnt, 0);
    check_model();
    @(posedge clk);
    @(posedge clk); #1;
    check_model();
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].st, vecs[i].rv, vecs[i].ins, vecs[i].we, vecs[i].rd, vecs[i].wd);
      chk($sformatf("vec%0d core_rst_n", i), core_rst_n, vecs[i].e_core);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d pass", i), pass, vecs[i].e_pass);
      chk($sformatf("vec%0d timeout", i), timeout, vecs[i].e_to);
      chk($sformatf("vec%0d result", i), result, vecs[i].e_res);
    end

    // Fibonacci run: x10 reaches 55, EBREAK retires in RUN cycle 40.
    tick(1'b1, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
    chk("fib rst low 1", core_rst_n, 0);
    idle_tick();
    chk("fib rst low 2", core_rst_n, 0);
    chk("fib busy in reset", busy, 1);
    idle_tick();
    chk("fib rst released", core_rst_n, 1);
    chk("fib cnt at run entry", cycle_cnt, 0);
    fa = 0; fb = 1;
    for (int k = 1; k < 40; k++) begin
      if (k <= 10) begin
        tick(1'b0, 1'b1, NOP, 1'b1, 5'd10, fb);
        ft = fa + fb; fa = fb; fb = ft;
      end else begin
        tick(1'b0, 1'b1, NOP, 1'b1, 5'd11, $urandom);
      end
    end
    tick(1'b0, 1'b1, EBREAK, 1'b0, 5'd0, 32'd0);
    chk("fib done", done, 1);
    chk("fib pass", pass, 1);
    chk("fib result", result, 55);
    chk("fib cycle_cnt", cycle_cnt, 40);
`ifdef RV_RUN_CTRL_PERF_EN
    chk("fib retire_cnt", retire_cnt, 40);
`endif

    // Timeout: no halt ever retires.
    tick(1'b1, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
    idle_tick();
    idle_tick();
    n = 0;
    while (!done && n < 300) begin
      tick(1'b0, 1'($urandom), rand_nonhalt(), 1'($urandom), 5'($urandom), $urandom);
      n++;
    end
    chk("timeout latency", n, TMO);
    chk("timeout flag", timeout, 1);
    chk("timeout pass", pass, 0);
    chk("timeout cycle_cnt", cycle_cnt, TMO);

    // Asynchronous reset in the middle of a RUN cycle.
    tick(1'b1, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
    idle_tick();
    idle_tick();
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, NOP, 1'b1, 5'd10, 32'd9);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async core_rst_n", core_rst_n, 0);
    chk("async busy", busy, 0);
    chk("async result", result, 0);
    chk("async cycle_cnt", cycle_cnt, 0);
    check_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_model();

    // Random runs against the model, with one more async reset midway.
    for (int i = 0; i < 1500; i++) begin
      logic        st;
      logic [31:0] ins;
      logic [4:0]  rd;
      logic [31:0] wd;
      st  = m_can_start() ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0:       ins = EBREAK;
          1:       ins = ECALL;
          default: ins = JAL0;
        endcase
      end else begin
        ins = rand_nonhalt();
      end
      rd = ($urandom_range(0, 2) == 0) ? 5'd10 : 5'($urandom);
      wd = ($urandom_range(0, 1) == 0) ? EXP : 32'($urandom_range(0, 99));
      tick(st, 1'($urandom), ins, 1'($urandom), rd, wd);
      if (i == 700) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        check_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_run_ctrl.md
# rv_run_ctrl

Parametrised run controller and completion monitor for the `rv_pl` pipeline. It sequences the core's reset release, counts run cycles, and detects program completion from the retire stream. It captures a watched architectural register from writeback and reports pass, fail or timeout as registered flags. It replaces fixed-delay bench runs with deterministic, self-checking termination, and is usable both in benches and on an FPGA debug wrapper.

## Interface
- `XLEN`, 32, data/PC width
- `CNT_W`, 32, width of the cycle and retire counters
- `RST_CYCLES`, 2, cycles `core_rst_n` is held low after `start` (≥1)
- `TIMEOUT`, 200, maximum RUN cycles before timeout (≥1)
- `WATCH_REG`, 10, register index captured into `result` (0 disables capture)
- `EXPECT`, 55, value `result` must equal for `pass`

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `retire_valid`  in  1  an instruction retires this cycle
- `retire_pc`  in  XLEN  PC of the retiring instruction
- `retire_instr`  in  32  encoding of the retiring instruction
- `wb_en`  in  1  register-file write this cycle
- `wb_rd`  in  5  destination register index
- `wb_data`  in  XLEN  write data
- `core_rst_n`  out  1  reset to `rv_pl`, active-low
- `busy`  out  1  state is RESET or RUN
- `done`  out  1  run finished (halt or timeout)
- `pass`  out  1  done, no timeout, and `result == EXPECT`
- `timeout`  out  1  run ended by timeout
- `result`  out  XLEN  last captured value of `WATCH_REG`
- `cycle_cnt`  out  CNT_W  RUN cycles elapsed
- `retire_cnt`  out  CNT_W  instructions retired; present only with `RV_RUN_CTRL_PERF_EN`

## Operation
- FSM states: IDLE, RESET, RUN, DONE.
- Reset values on assertion of `rst_n`, asynchronous and effective mid-run: state IDLE, `core_rst_n`=0, `busy`/`done`/`pass`/`timeout`=0, `result`=0, `cycle_cnt`=0, `retire_cnt`=0.
- IDLE or DONE, with `start`=1:
  - go to RESET.
  - clear `result`, the counters, `done`, `pass` and `timeout`.
  - load the reset counter with `RST_CYCLES`.
- RESET:
  - `core_rst_n`=0.
  - decrement the reset counter; at 1, go to RUN.
- RUN:
  - `core_rst_n`=1.
  - `cycle_cnt` increments each cycle, saturating at all-ones.
  - a halt is a cycle with `retire_valid`=1 and `retire_instr` equal to `0x00100073` (EBREAK), `0x00000073` (ECALL), or `0x0000006F` (`jal x0,0` self-loop).
  - halt → DONE with `done`=1 and `pass` evaluated.
  - no halt and `cycle_cnt == TIMEOUT-1` → DONE with `done`=1, `timeout`=1, `pass`=0.
- DONE:
  - `core_rst_n` stays 1; the core free-runs.
  - outputs are held.
  - `start` begins a new run.
- Capture:
  - any cycle in RUN with `wb_en` and `wb_rd == WATCH_REG != 0`: `result <= wb_data`.
  - writes in other states are ignored.
- `start` in RESET or RUN is ignored.
- Simultaneous events:
  - writeback and halt in the same cycle: the write is captured and `pass` compares the new value.
  - halt and timeout in the same cycle: halt wins, `timeout`=0.

## Timing
- `start` high at edge N → RESET from N+1; `core_rst_n` low during cycles N+1..N+`RST_CYCLES`; RUN from N+`RST_CYCLES`+1.
- `cycle_cnt` reads 0 in the first RUN cycle.
- Halt retiring in cycle M → `done`/`pass` high from M+1; `busy` low from M+1.
- Timeout: `done`=1 and `timeout`=1 exactly `TIMEOUT` cycles after RUN entry.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `RV_RUN_CTRL_PERF_EN` defined:
  - adds `retire_cnt`, which increments on `retire_valid` in RUN (halt instruction included) and saturates.
  - adds a port `perf_sat` (out, 1), set when either counter saturates and cleared on `start`.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

## Test plan
- `rst_n` low 2 cycles, then `start` pulse → `core_rst_n` low for exactly 2 cycles, `busy`=1, `cycle_cnt`=0 on RUN entry.
- Fibonacci stream writes x10=55, then EBREAK retires at RUN cycle 40 → `done`=1, `pass`=1, `result`=55, `cycle_cnt`=40 the following cycle.
- x10 written as 54, then ECALL → `done`=1, `pass`=0, `timeout`=0, `result`=54.
- No halt with `TIMEOUT`=200 → `done`=1 and `timeout`=1 exactly 200 cycles after RUN entry; `pass`=0.
- Writeback of x10=55 and `jal x0,0` in the same cycle → `pass`=1. Writes to x0 or x11 leave `result` unchanged.
- `rst_n` pulsed low mid-RUN → all outputs return to reset values immediately. `start` in DONE re-runs with counters cleared; with `RV_RUN_CTRL_PERF_EN`, `retire_cnt` equals the number of retire pulses, halt included.
